// File: rtl/exec_pkg.sv
// Shared types and helpers for the execute stage: ALU opcodes, FSM states,
// forwarding selectors, and the register-file sign-extension function.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8,
        ALU_MUL = 4'd9
    } aluop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    // Widest datapath sext() can serve; callers size-cast the result down to XLEN.
    localparam int SEXT_W = 128;

    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] value,
                                               input int src_w);
        logic [SEXT_W-1:0] shifted;
        shifted = value << (SEXT_W - src_w);
        return $unsigned($signed(shifted) >>> (SEXT_W - src_w));
    endfunction

    // MEM is younger than WB, so it wins; x0 is hardwired and never forwarded.
    function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                            input logic [4:0] rd_mem,
                                            input logic       regwrite_mem,
                                            input logic [4:0] rd_wb,
                                            input logic       regwrite_wb);
        if (regwrite_mem && (rd_mem != 5'd0) && (rd_mem == rs)) return FWD_MEM;
        if (regwrite_wb && (rd_wb != 5'd0) && (rd_wb == rs)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/exec_stage_mc_seq_mul.sv
// Iterative shift-add multiplier: one partial product per step, XLEN steps.
// Only the low XLEN bits are kept, which are sign-agnostic.
module seq_mul
    import exec_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            last_o,
    output logic [XLEN-1:0] product_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  acc_q;
    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  mplier_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            count_q  <= '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CNT_W'(1);
        end
    end

    assign last_o    = (count_q == CNT_W'(XLEN - 1));
    assign product_o = acc_q;

endmodule

// File: rtl/exec_stage_mc.sv
// Pipelined execute stage: operand forwarding, ALU, iterative multiplier and a
// registered EX/MEM output slot with valid/ready backpressure.
module exec_stage_mc
    import exec_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RF_W    = 32,
    parameter int ITYPE_W = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               id_valid_i,
    output logic               ex_ready_o,
    input  logic               flush_i,
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    input  logic [4:0]         rd_i,
    input  logic [RF_W-1:0]    rs1_data_i,
    input  logic [RF_W-1:0]    rs2_data_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               regwrite_i,
    input  logic               memread_i,
    input  logic               memwrite_i,
    input  logic               alusrc_i,
    input  logic               memtoreg_i,
    input  aluop_e             aluop_i,
    input  logic [2:0]         funct3_i,
    input  logic [ITYPE_W-1:0] itype_i,
    input  logic [4:0]         rd_mem_i,
    input  logic [4:0]         rd_wb_i,
    input  logic               regwrite_mem_i,
    input  logic               regwrite_wb_i,
    input  logic [XLEN-1:0]    mem_fwd_data_i,
    input  logic [XLEN-1:0]    wb_data_i,
    input  logic               mem_ready_i,
    output logic               ex_valid_o,
    output logic [XLEN-1:0]    ex_alu_result_o,
    output logic [XLEN-1:0]    ex_store_data_o,
    output logic [XLEN-1:0]    ex_branch_target_o,
    output logic               ex_zero_o,
    output logic               ex_ltz_o,
    output logic [4:0]         ex_rd_o,
    output logic               ex_regwrite_o,
    output logic               ex_memread_o,
    output logic               ex_memwrite_o,
    output logic               ex_memtoreg_o,
    output logic [2:0]         ex_funct3_o,
    output logic [ITYPE_W-1:0] ex_itype_o
);

    localparam int SHAMT_W = $clog2(XLEN);

    // Everything that travels alongside the result into the EX/MEM slot.
    typedef struct packed {
        logic [XLEN-1:0]    store_data;
        logic [XLEN-1:0]    branch_target;
        logic [4:0]         rd;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic [2:0]         funct3;
        logic [ITYPE_W-1:0] itype;
    } meta_t;

    state_e          state_q, state_d;
    fwd_sel_e        rs1_sel, rs2_sel;
    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic [XLEN-1:0] op1, fwd_rs2, op2;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mul_product;
    logic            mul_last;
    meta_t           meta_in, mul_meta_q, slot_meta_q;
    logic [XLEN-1:0] slot_result_q;
    logic            slot_zero_q, slot_ltz_q;
    logic            slot_free;
    logic            start_mul, step_mul, load_alu, load_mul;

    // ---------------- operand forwarding ----------------
    assign rf_rs1  = XLEN'(sext(SEXT_W'(rs1_data_i), RF_W));
    assign rf_rs2  = XLEN'(sext(SEXT_W'(rs2_data_i), RF_W));
    assign rs1_sel = fwd_select(rs1_i, rd_mem_i, regwrite_mem_i, rd_wb_i, regwrite_wb_i);
    assign rs2_sel = fwd_select(rs2_i, rd_mem_i, regwrite_mem_i, rd_wb_i, regwrite_wb_i);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        op1 = rf_rs1;
        case (rs1_sel)
            FWD_MEM: op1 = mem_fwd_data_i;
            FWD_WB:  op1 = wb_data_i;
            default: op1 = rf_rs1;
        endcase
        fwd_rs2 = rf_rs2;
        case (rs2_sel)
            FWD_MEM: fwd_rs2 = mem_fwd_data_i;
            FWD_WB:  fwd_rs2 = wb_data_i;
            default: fwd_rs2 = rf_rs2;
        endcase
    end

    assign op2 = alusrc_i ? imm_i : fwd_rs2;

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        alu_result = '0;
        case (aluop_i)
            ALU_ADD: alu_result = op1 + op2;
            ALU_SUB: alu_result = op1 - op2;
            ALU_AND: alu_result = op1 & op2;
            ALU_OR:  alu_result = op1 | op2;
            ALU_XOR: alu_result = op1 ^ op2;
            ALU_SLL: alu_result = op1 << op2[SHAMT_W-1:0];
            ALU_SRL: alu_result = op1 >> op2[SHAMT_W-1:0];
            ALU_SRA: alu_result = $unsigned($signed(op1) >>> op2[SHAMT_W-1:0]);
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        meta_in               = '0;
        meta_in.store_data    = fwd_rs2;
        meta_in.branch_target = pc_i + imm_i;
        meta_in.rd            = rd_i;
        meta_in.regwrite      = regwrite_i;
        meta_in.memread       = memread_i;
        meta_in.memwrite      = memwrite_i;
        meta_in.memtoreg      = memtoreg_i;
        meta_in.funct3        = funct3_i;
        meta_in.itype         = itype_i;
    end

    // ---------------- multiplier ----------------
    seq_mul #(
        .XLEN (XLEN)
    ) u_seq_mul (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (start_mul),
        .step_i    (step_mul),
        .a_i       (op1),
        .b_i       (op2),
        .last_o    (mul_last),
        .product_o (mul_product)
    );

    // ---------------- control FSM ----------------
    assign slot_free = !ex_valid_o || mem_ready_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_mul) state_d = MUL;
                MUL:     if (mul_last)  state_d = DONE;
                DONE:    if (load_mul)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ex_ready_o = 1'b0;
        start_mul  = 1'b0;
        step_mul   = 1'b0;
        load_alu   = 1'b0;
        load_mul   = 1'b0;
        case (state_q)
            IDLE: begin
                ex_ready_o = slot_free && !flush_i;
                if (id_valid_i && ex_ready_o) begin
                    start_mul = (aluop_i == ALU_MUL);
                    load_alu  = (aluop_i != ALU_MUL);
                end
            end
            MUL:     step_mul = !flush_i;
            DONE:    load_mul = slot_free && !flush_i;
            default: ex_ready_o = 1'b0;
        endcase
    end

    // Control and metadata for a multiply are captured on accept, since ID/EX moves on.
    always_ff @(posedge clk_i or negedge reset_i) begin
        // NOTE: these holding registers are reset so outputs never expose X after a reset.
        if (!reset_i) begin
            mul_meta_q <= '0;
        end else if (start_mul) begin
            mul_meta_q <= meta_in;
        end
    end

    // ---------------- EX/MEM output slot ----------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ex_valid_o    <= 1'b0;
            slot_result_q <= '0;
            slot_zero_q   <= 1'b0;
            slot_ltz_q    <= 1'b0;
            slot_meta_q   <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (load_alu) begin
            ex_valid_o    <= 1'b1;
            slot_result_q <= alu_result;
            slot_zero_q   <= (alu_result == '0);
            slot_ltz_q    <= alu_result[XLEN-1];
            slot_meta_q   <= meta_in;
        end else if (load_mul) begin
            ex_valid_o    <= 1'b1;
            slot_result_q <= mul_product;
            slot_zero_q   <= (mul_product == '0);
            slot_ltz_q    <= mul_product[XLEN-1];
            slot_meta_q   <= mul_meta_q;
        end else if (mem_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

    assign ex_alu_result_o    = slot_result_q;
    assign ex_zero_o          = slot_zero_q;
    assign ex_ltz_o           = slot_ltz_q;
    assign ex_store_data_o    = slot_meta_q.store_data;
    assign ex_branch_target_o = slot_meta_q.branch_target;
    assign ex_rd_o            = slot_meta_q.rd;
    assign ex_regwrite_o      = slot_meta_q.regwrite;
    assign ex_memread_o       = slot_meta_q.memread;
    assign ex_memwrite_o      = slot_meta_q.memwrite;
    assign ex_memtoreg_o      = slot_meta_q.memtoreg;
    assign ex_funct3_o        = slot_meta_q.funct3;
    assign ex_itype_o         = slot_meta_q.itype;

endmodule

// File: doc/exec_stage_mc.md
# exec_stage_mc

Parametrised, pipelined execute stage for the in-order RISC-V core. It adds an XLEN-generic datapath, MEM/WB operand forwarding, a registered EX/MEM output slot with valid/ready backpressure, and an iterative multi-cycle multiplier that stalls decode. It sits between the ID/EX register and the memory stage. It drives the branch target, the ALU result, store data and the forwarded control to MEM.

## Interface
Parameters:
- XLEN, 64, datapath width (PC, immediates, ALU, results)
- RF_W, 32, register-file read width; operands are sign-extended from RF_W to XLEN
- ITYPE_W, 3, instruction-type tag width (passed through)

Ports (reset is asynchronous, active-low, on reset_i; single clock clk_i):
- clk_i  in  1  clock, rising edge
- reset_i  in  1  async active-low reset
- id_valid_i  in  1  ID/EX holds a valid instruction
- ex_ready_o  out  1  stage accepts the instruction this cycle
- flush_i  in  1  kill the in-flight and the offered instruction
- rs1_i, rs2_i, rd_i  in  5 each  register indices
- rs1_data_i, rs2_data_i  in  RF_W each  register-file data
- imm_i, pc_i  in  XLEN each  immediate, PC
- regwrite_i, memread_i, memwrite_i, alusrc_i, memtoreg_i  in  1 each  control
- aluop_i  in  4  exec_pkg::aluop_e
- funct3_i  in  3; itype_i  in  ITYPE_W  pass-through
- rd_mem_i, rd_wb_i  in  5 each; regwrite_mem_i, regwrite_wb_i  in  1 each
- mem_fwd_data_i, wb_data_i  in  XLEN each  forwarding sources
- mem_ready_i  in  1  MEM stage accepts the output slot
- ex_valid_o  out  1  output slot holds a valid result
- ex_alu_result_o, ex_store_data_o, ex_branch_target_o  out  XLEN each
- ex_zero_o, ex_ltz_o, ex_rd_o(5), ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_funct3_o(3), ex_itype_o(ITYPE_W)  out  registered copies

## Operation
- Forwarding is resolved per operand. MEM wins when regwrite_mem_i is set, rd_mem_i is nonzero and rd_mem_i equals the source index. Otherwise WB wins under the same rule. Otherwise the sign-extended RF data is used. Index x0 is never forwarded.
- op2 = alusrc_i ? imm_i : fwd_rs2. The store data is always fwd_rs2.
- ALU ops are ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT and MUL.
  - Shift amount is op2[$clog2(XLEN)-1:0].
  - SLT is signed and produces 0 or 1.
  - MUL returns the low XLEN bits of op1*op2, which is the same for signed and unsigned operands.
- zero = result==0. ltz = result[XLEN-1]. Branch target = pc_i+imm_i, modulo 2^XLEN.
- slot_free = !ex_valid_o || mem_ready_i.
- FSM states:
  - IDLE: ex_ready_o = slot_free && !flush_i.
    - Non-MUL accept: the output slot loads at the edge and the state stays IDLE.
    - MUL accept: operands, control and metadata latch, count=0, and the state goes to MUL. The output slot is unchanged and simply drains when mem_ready_i is high.
  - MUL: one shift-add step per cycle. After XLEN steps (count==XLEN-1) the state goes to DONE. ex_ready_o=0.
  - DONE: when slot_free, load the product into the output slot and go to IDLE. Otherwise hold. ex_ready_o=0.
- When mem_ready_i is high and no load occurs, ex_valid_o clears.
- flush_i:
  - Synchronously clears ex_valid_o and returns the FSM to IDLE, discarding any multiply.
  - The offered instruction is not accepted in that cycle.
  - flush_i has priority over every other event.
- Simultaneous drain and load: a new result may load on the same edge the old one is consumed, giving back-to-back throughput of 1 per cycle for ALU ops.

## Timing
- All outputs come from registers, except ex_ready_o, which is combinational from state, ex_valid_o, mem_ready_i and flush_i.
- Reset values:
  - all ex_* outputs are 0
  - ex_valid_o=0
  - state is IDLE and count is 0
  - ex_ready_o evaluates to 1 once reset deasserts, with flush_i low
- Reset mid-multiply aborts the multiply immediately.
- ALU op latency: 1. The result is valid on the cycle after the accept edge.
- MUL latency: XLEN+1 edges from accept to ex_valid_o rising, with no backpressure (65 for XLEN=64). Each cycle of backpressure in DONE adds 1.
- Forwarding inputs are sampled only on the accept edge. A multiply ignores them afterwards.

## Structure
- exec_pkg holds:
  - aluop_e (4-bit enum)
  - state_e {IDLE, MUL, DONE}
  - fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM}
  - the function sext(RF_W→XLEN)
- One sub-module, seq_mul. It is the iterative shift-add multiplier with start/done, parametrised by XLEN and owning the count. The FSM and output slot stay in exec_stage_mc.

## Test plan
- Forward priority: rs1=5 with rd_mem_i=5/regwrite and rd_wb_i=5/regwrite, mem data 0x11, wb data 0x22, ADD with imm 1 → result 0x12. Drop the MEM match → 0x23.
- x0 guard: rs1=0, rd_mem_i=0, regwrite_mem_i=1, mem data 0xFF, rs1_data_i=0 → operand 0. Then rs1_data_i=0x8000_0000 → operand 0xFFFF_FFFF_8000_0000.
- MUL: 7 × −3, XLEN=64 → ex_valid_o rises exactly 65 edges after accept with result 0xFFFF_FFFF_FFFF_FFEB and ltz=1. ex_ready_o is 0 throughout.
- Backpressure: mem_ready_i=0 while issuing three ADDs → only the first loads and ex_ready_o drops. Release → one result per cycle, in order, none lost or duplicated.
- Flush mid-MUL: assert flush_i at step 30 → next cycle ex_valid_o=0, state IDLE, ex_ready_o=1. No product appears.
- Async reset mid-MUL: reset_i low between edges → outputs are 0 immediately. After release, a SUB 10−4 yields 6 one cycle after accept.
